// File: rtl/debounced_updown_counter.sv
// Up/down counter fed by raw push buttons: each button is synchronised, debounced
// and edge-detected so a single physical press moves the count by exactly one.
module debounced_updown_counter #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SATURATE        = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_increment,
  input  logic         btn_decrement,
  input  logic         btn_clear,
  output logic [N-1:0] count,
  output logic         at_zero,
  output logic         at_max,
  output logic         overflow,
  output logic         underflow
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0]  MAX      = '1;

  // Button lanes: bit 0 = increment, bit 1 = decrement, bit 2 = clear.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    db_q, db_d;
  logic [2:0]    db_dly_q;
  logic [CW-1:0] dbc_q [3];
  logic [CW-1:0] dbc_d [3];
  logic [2:0]    press;

  logic [N-1:0]  count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  assign btn_raw = {btn_clear, btn_decrement, btn_increment};

  // A level change is accepted only after sync2 has differed from db for a full window.
  always_comb begin
    db_d = db_q;
    for (int b = 0; b < 3; b++) begin
      dbc_d[b] = '0;
      if (sync2_q[b] != db_q[b]) begin
        if (dbc_q[b] == CNT_LAST) begin
          db_d[b] = sync2_q[b];
        end else begin
          dbc_d[b] = dbc_q[b] + CW'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (press[2]) begin
      count_d = '0;
    end else if (press[0] && !press[1]) begin
      if (count_q == MAX) begin
        if (SATURATE == 0) begin
          count_d = '0;
          ovf_d   = 1'b1;
        end
      end else begin
        count_d = count_q + N'(1);
      end
    end else if (press[1] && !press[0]) begin
      if (count_q == '0) begin
        if (SATURATE == 0) begin
          count_d = MAX;
          unf_d   = 1'b1;
        end
      end else begin
        count_d = count_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int b = 0; b < 3; b++) begin
        dbc_q[b] <= '0;
      end
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int b = 0; b < 3; b++) begin
        dbc_q[b] <= dbc_d[b];
      end
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign count     = count_q;
  assign at_zero   = (count_q == '0);
  assign at_max    = (count_q == MAX);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
